// File: rtl/conv_pkg.sv
// Shared state type, sizing helpers and requantisation for conv_layer_engine.
// CONV_SAT_EN: positive overflow saturates in requant instead of wrapping.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int unsigned REQ_IN_W  = 96;
    localparam int unsigned REQ_OUT_W = 32;

    function automatic int unsigned taps(input int unsigned kd, input int unsigned chin);
        return kd * kd * chin;
    endfunction

    function automatic int unsigned addr_w(input int unsigned kd, input int unsigned chin);
        return (taps(kd, chin) > 1) ? 32'($clog2(taps(kd, chin))) : 32'd1;
    endfunction

    // ReLU, drop FRAC bits, keep WIDTH-1 magnitude bits with a zero sign bit.
    function automatic logic [REQ_OUT_W-1:0] requant(input logic signed [REQ_IN_W-1:0] acc,
                                                     input int unsigned frac,
                                                     input int unsigned width);
        logic [REQ_IN_W-1:0]  mag;
        logic [REQ_OUT_W-1:0] max_pos;
        max_pos = (REQ_OUT_W'(1) << (width - 1)) - REQ_OUT_W'(1);
        mag     = REQ_IN_W'(acc >>> frac);
        if (acc[REQ_IN_W-1]) begin
            return '0;
        end
`ifdef CONV_SAT_EN
        if ((mag >> (width - 1)) != '0) begin
            return max_pos;
        end
`endif
        return REQ_OUT_W'(mag) & max_pos;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate lane; clr restarts the sum with the current product.
module conv_mac #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ACC_W = 2 * WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] pix,
    input  logic signed [WIDTH-1:0] ker,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;

    assign prod     = (2*WIDTH)'(pix) * (2*WIDTH)'(ker);
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= en ? prod_ext : '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/conv_layer_engine.sv
// Output-stationary conv layer engine: one streamed IFM pixel feeds DSP_NO MAC lanes.
// CONV_SAT_EN selects saturating requantisation (see conv_pkg::requant).
module conv_layer_engine
    import conv_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FRAC       = 14,
    parameter int unsigned DSP_NO     = 128,
    parameter int unsigned CHIN       = 32,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned WOUT       = 128,
    parameter int unsigned ACC_W      = 2 * WIDTH + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                layer_en,
    input  logic [WIDTH-1:0]                    ifm,
    input  logic                                ram_feedback,
    output logic [addr_w(KERNEL_DIM, CHIN)-1:0] weight_addr,
    input  logic [WIDTH*DSP_NO-1:0]             weights,
    input  logic [2*WIDTH*DSP_NO-1:0]           bias,
    output logic [WIDTH*DSP_NO-1:0]             ofm,
    output logic                                ofm_sample,
    output logic                                busy,
    output logic                                layer_finish
);

    localparam int unsigned TAPS   = taps(KERNEL_DIM, CHIN);
    localparam int unsigned AW     = addr_w(KERNEL_DIM, CHIN);
    localparam int unsigned PIXELS = WOUT * WOUT;
    localparam int unsigned PW     = (PIXELS > 1) ? 32'($clog2(PIXELS)) : 32'd1;
    localparam int unsigned SUM_W  = ACC_W + 1;

    state_t                  state, state_next;
    logic [AW-1:0]           tap_cnt;
    logic [PW-1:0]           pix_cnt;
    logic                    last_tap, end_flag, en_d;
    logic [WIDTH-1:0]        ifm_d;
    logic                    accept_c, drain_c, tap_wrap_c, pix_last_c;
    logic signed [ACC_W-1:0] acc [DSP_NO];
    logic signed [SUM_W-1:0] sum [DSP_NO];

    assign tap_wrap_c   = (tap_cnt == AW'(TAPS - 1));
    assign pix_last_c   = (pix_cnt == PW'(PIXELS - 1));
    assign drain_c      = (state == DRAIN);
    assign weight_addr  = tap_cnt;
    assign layer_finish = end_flag && !ram_feedback;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Taps are accepted in IDLE and RUN; the cycle after the last tap is a bubble for the MAC.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (layer_en) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_tap) begin
                    state_next = DRAIN;
                end else begin
                    accept_c = layer_en;
                end
            end
            DRAIN:   state_next = pix_last_c ? DONE : RUN;
            default: state_next = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_cnt    <= '0;
            pix_cnt    <= '0;
            last_tap   <= 1'b0;
            end_flag   <= 1'b0;
            en_d       <= 1'b0;
            ifm_d      <= '0;
            busy       <= 1'b0;
            ofm_sample <= 1'b0;
        end else begin
            en_d       <= accept_c;
            last_tap   <= accept_c && tap_wrap_c;
            busy       <= (state_next == RUN) || (state_next == DRAIN);
            ofm_sample <= drain_c;
            if (accept_c) begin
                ifm_d   <= ifm;
                tap_cnt <= tap_wrap_c ? '0 : tap_cnt + AW'(1);
            end
            if (drain_c) begin
                pix_cnt <= pix_cnt + PW'(1);
                if (pix_last_c) begin
                    end_flag <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
        conv_mac #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
        ) u_mac (
            .clk (clk),
            .rst (rst),
            .clr (drain_c),
            .en  (en_d),
            .pix (ifm_d),
            .ker (weights[g*WIDTH +: WIDTH]),
            .acc (acc[g])
        );
        assign sum[g] = SUM_W'(acc[g]) + SUM_W'($signed(bias[g*2*WIDTH +: 2*WIDTH]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofm <= '0;
        end else if (drain_c) begin
            for (int i = 0; i < DSP_NO; i++) begin
                ofm[i*WIDTH +: WIDTH] <= WIDTH'(requant(REQ_IN_W'(sum[i]), FRAC, WIDTH));
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed bench for conv_layer_engine: 1x1 kernel, 2 channels, 2 lanes, 2x2 output map.
// Honours CONV_SAT_EN for the overflow expectation.
module tb_conv_layer_engine;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DSP_NO = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          layer_en;
    logic [WIDTH-1:0]              ifm;
    logic                          ram_feedback;
    logic [0:0]                    weight_addr;
    logic [WIDTH*DSP_NO-1:0]       weights;
    logic [2*WIDTH*DSP_NO-1:0]     bias;
    logic [WIDTH*DSP_NO-1:0]       ofm;
    logic                          ofm_sample;
    logic                          busy;
    logic                          layer_finish;

    logic [WIDTH*DSP_NO-1:0]       rom [2];
    int                            n_cmp = 0;
    int                            n_err = 0;

    conv_layer_engine #(
        .WIDTH      (16),
        .FRAC       (14),
        .DSP_NO     (2),
        .CHIN       (2),
        .KERNEL_DIM (1),
        .WOUT       (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .layer_en     (layer_en),
        .ifm          (ifm),
        .ram_feedback (ram_feedback),
        .weight_addr  (weight_addr),
        .weights      (weights),
        .bias         (bias),
        .ofm          (ofm),
        .ofm_sample   (ofm_sample),
        .busy         (busy),
        .layer_finish (layer_finish)
    );

    always #5 clk = ~clk;

    // Synchronous weight ROM: data valid one cycle after the address.
    always @(posedge clk) weights <= rom[weight_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rom(input logic [15:0] l0t0, input logic [15:0] l1t0,
                           input logic [15:0] l0t1, input logic [15:0] l1t1);
        rom[0] = {l1t0, l0t0};
        rom[1] = {l1t1, l0t1};
    endtask

    task automatic check_reset_state(input string tag);
        check($sformatf("%s.ofm", tag), ofm, 32'h0);
        check($sformatf("%s.ofm_sample", tag), ofm_sample, 32'h0);
        check($sformatf("%s.busy", tag), busy, 32'h0);
        check($sformatf("%s.layer_finish", tag), layer_finish, 32'h0);
        check($sformatf("%s.weight_addr", tag), weight_addr, 32'h0);
    endtask

    // Two taps with an optional stall between them; total counts cycles from tap0 to ofm_sample.
    task automatic run_pixel(input string tag, input logic [15:0] px0, input logic [15:0] px1,
                             input int stall, input int exp_total,
                             input logic [15:0] exp0, input logic [15:0] exp1);
        int total;
        int lat;
        total    = 0;
        ifm      = px0;
        layer_en = 1'b1;
        tick();
        total++;
        check($sformatf("%s.busy", tag), busy, 32'h1);
        check($sformatf("%s.no_early_sample", tag), ofm_sample, 32'h0);
        layer_en = 1'b0;
        ifm      = 16'h7FFF;
        repeat (stall) begin
            tick();
            total++;
        end
        check($sformatf("%s.weight_addr", tag), weight_addr, 32'h1);
        ifm      = px1;
        layer_en = 1'b1;
        tick();
        total++;
        lat      = 1;
        layer_en = 1'b0;
        ifm      = 16'h7FFF;
        while (!ofm_sample && lat < 20) begin
            tick();
            total++;
            lat++;
        end
        check($sformatf("%s.latency", tag), lat, 32'd3);
        check($sformatf("%s.total_cycles", tag), total, 32'(exp_total));
        check($sformatf("%s.ofm0", tag), ofm[15:0], 32'(exp0));
        check($sformatf("%s.ofm1", tag), ofm[31:16], 32'(exp1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [15:0] ovf_exp;
`ifdef CONV_SAT_EN
        ovf_exp = 16'h7FFF;
`else
        ovf_exp = 16'h7FF8;
`endif
        rst          = 1'b0;
        layer_en     = 1'b0;
        ifm          = '0;
        ram_feedback = 1'b1;
        bias         = '0;
        set_rom(16'h2000, 16'h2000, 16'h2000, 16'h2000);
        tick();
        tick();
        check_reset_state("reset");
        rst = 1'b1;
        tick();

        // 0.5 weights, 1.0 pixels, two taps -> 1.0 per lane.
        run_pixel("px0_basic", 16'h4000, 16'h4000, 0, 4, 16'h4000, 16'h4000);
        check("px0.layer_finish", layer_finish, 32'h0);
        run_pixel("px1_stall", 16'h4000, 16'h4000, 5, 9, 16'h4000, 16'h4000);
        set_rom(16'hE000, 16'h2000, 16'hE000, 16'h2000);
        run_pixel("px2_relu", 16'h4000, 16'h4000, 0, 4, 16'h0000, 16'h4000);
        set_rom(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_pixel("px3_ovf", 16'h7FFF, 16'h7FFF, 0, 4, ovf_exp, ovf_exp);

        // Last pixel drained: layer done but downstream RAM still busy.
        check("done.busy", busy, 32'h0);
        check("done.finish_blocked", layer_finish, 32'h0);
        ram_feedback = 1'b0;
        #1;
        check("done.finish", layer_finish, 32'h1);
        ram_feedback = 1'b1;
        #1;
        check("done.finish_reblocked", layer_finish, 32'h0);
        ram_feedback = 1'b0;
        layer_en     = 1'b1;
        ifm          = 16'h4000;
        pulses       = 0;
        repeat (6) begin
            tick();
            if (ofm_sample) pulses++;
        end
        layer_en = 1'b0;
        check("done.no_sample", pulses, 32'd0);
        check("done.weight_addr", weight_addr, 32'h0);
        check("done.finish_held", layer_finish, 32'h1);

        // Second layer: distinct per-tap weights and signed biases.
        rst = 1'b0;
        tick();
        check_reset_state("reset2");
        rst = 1'b1;
        bias = {32'hF800_0000, 32'h0400_0000};
        set_rom(16'h4000, 16'h2000, 16'h0000, 16'h4000);
        tick();
        run_pixel("b0_bias", 16'h4000, 16'h2000, 0, 4, 16'h5000, 16'h2000);
        check("b0.layer_finish", layer_finish, 32'h0);

        // Abort mid-pixel with a large partial sum in flight.
        set_rom(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        ifm      = 16'h7FFF;
        layer_en = 1'b1;
        tick();
        layer_en = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_reset_state("abort");
        tick();
        bias = '0;
        set_rom(16'h2000, 16'h2000, 16'h2000, 16'h2000);
        rst = 1'b1;
        tick();
        run_pixel("rerun", 16'h4000, 16'h4000, 0, 4, 16'h4000, 16'h4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
